// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures div_clk_in period in clk cycles, tracks lock, raises sticky errors.
// Optional duty-cycle check enabled by defining CLKMON_DUTY_CHECK_EN.
module clk_div_monitor #(
   parameter int CNT_W      = 16,
   parameter int EXP_PERIOD = 10,
   parameter int TOL        = 1,
   parameter int LOCK_CNT   = 4,
   parameter int LOSS_LIMIT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_clk_in,
   input  logic             clr_err,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic [CNT_W-1:0] high_time,
   output logic             lock,
   output logic             err_period,
   output logic             err_loss,
   output logic             err_duty
);

   localparam int GW = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCKED} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [GW-1:0]    good_cnt, good_nxt;
   logic [CNT_W-1:0] period_nxt;
   logic             pv_nxt, lock_nxt;
   logic             set_period, set_loss;
   logic             s1, s2, rise, good;

   assign rise = s1 & ~s2;
   assign good = (cnt >= CNT_W'(EXP_PERIOD - TOL)) && (cnt <= CNT_W'(EXP_PERIOD + TOL));

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = (state != IDLE && cnt != '1) ? cnt + CNT_W'(1) : cnt;
      good_nxt   = good_cnt;
      period_nxt = period;
      pv_nxt     = 1'b0;
      lock_nxt   = lock;
      set_period = 1'b0;
      set_loss   = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         lock_nxt  = 1'b0;
         good_nxt  = '0;
      end else if (state == IDLE) begin
         state_nxt = ACQ;
      end else if (rise) begin
         cnt_nxt = CNT_W'(1);
         if (state == ACQ) begin
            state_nxt = MEAS;
         end else begin
            period_nxt = cnt;
            pv_nxt     = 1'b1;
            if (good) begin
               if (state == MEAS) begin
                  if (good_cnt == GW'(LOCK_CNT - 1)) begin
                     good_nxt  = GW'(LOCK_CNT);
                     state_nxt = LOCKED;
                     lock_nxt  = 1'b1;
                  end else begin
                     good_nxt = good_cnt + GW'(1);
                  end
               end
            end else begin
               set_period = 1'b1;
               good_nxt   = '0;
               lock_nxt   = 1'b0;
               state_nxt  = MEAS;
            end
         end
      end else if (cnt == CNT_W'(LOSS_LIMIT)) begin
         set_loss  = 1'b1;
         lock_nxt  = 1'b0;
         good_nxt  = '0;
         cnt_nxt   = '0;
         state_nxt = ACQ;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         good_cnt     <= '0;
         s1           <= 1'b0;
         s2           <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         lock         <= 1'b0;
         err_period   <= 1'b0;
         err_loss     <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         good_cnt     <= good_nxt;
         s1           <= div_clk_in;
         s2           <= s1;
         period       <= period_nxt;
         period_valid <= pv_nxt;
         lock         <= lock_nxt;
         // a new error outranks a simultaneous clear
         err_period   <= (err_period & ~clr_err) | set_period;
         err_loss     <= (err_loss & ~clr_err) | set_loss;
      end
   end

`ifdef CLKMON_DUTY_CHECK_EN
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W:0]   two_high, duty_diff;
   logic             fall, duty_hit;

   assign fall = ~s1 & s2;

   always_comb begin
      two_high  = {high_time, 1'b0};
      duty_diff = (two_high >= {1'b0, cnt}) ? two_high - {1'b0, cnt} : {1'b0, cnt} - two_high;
      duty_hit  = en && rise && (state == MEAS || state == LOCKED) &&
                  (duty_diff > (CNT_W+1)'(2 * TOL));
   end

   // hcnt restarts at 1 on the rise cycle so high_time counts the same way as period
   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt      <= '0;
         high_time <= '0;
         err_duty  <= 1'b0;
      end else begin
         if (rise)
            hcnt <= CNT_W'(1);
         else if (hcnt != '1)
            hcnt <= hcnt + CNT_W'(1);
         if (fall)
            high_time <= hcnt;
         err_duty <= (err_duty & ~clr_err) | duty_hit;
      end
   end
`else
   assign high_time = '0;
   assign err_duty  = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized self-checking bench for clk_div_monitor against a timestamp-based reference model.
module tb_clk_div_monitor;

   localparam int CNT_W      = 16;
   localparam int EXP_PERIOD = 10;
   localparam int TOL        = 1;
   localparam int LOCK_CNT   = 4;
   localparam int LOSS_LIMIT = 64;
`ifdef CLKMON_DUTY_CHECK_EN
   localparam bit DUTY_ON = 1'b1;
`else
   localparam bit DUTY_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, en, div_clk_in, clr_err;
   logic [CNT_W-1:0] period, high_time;
   logic period_valid, lock, err_period, err_loss, err_duty;

   clk_div_monitor #(
      .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL),
      .LOCK_CNT(LOCK_CNT), .LOSS_LIMIT(LOSS_LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .div_clk_in(div_clk_in), .clr_err(clr_err),
      .period(period), .period_valid(period_valid), .high_time(high_time),
      .lock(lock), .err_period(err_period), .err_loss(err_loss), .err_duty(err_duty)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference model: time measured as edge index differences, not counters.
   int n = 0;
   bit m_valid = 1'b0;
   int mode = 0;          // 0 off, 1 waiting for first rise, 2 measuring
   int origin = 0;        // edge index from which the current interval is timed
   int good = 0;
   int hi_rise = 0;
   bit h1 = 1'b0, h2 = 1'b0;
   int m_period = 0, m_high = 0;
   bit m_pv = 1'b0, m_lock = 1'b0, m_ep = 1'b0, m_el = 1'b0, m_ed = 1'b0;

   always @(posedge clk) begin
      bit r, f, setp, setl, setd;
      int elapsed;
      n = n + 1;
      if (rst) begin
         m_valid = 1'b1;
         mode = 0; origin = n; good = 0; hi_rise = n + 1;
         m_period = 0; m_high = 0;
         m_pv = 0; m_lock = 0; m_ep = 0; m_el = 0; m_ed = 0;
         h1 = 0; h2 = 0;
      end else begin
         r = h1 && !h2;
         f = !h1 && h2;
         elapsed = n - origin;
         setp = 0; setl = 0; setd = 0; m_pv = 0;
         if (!en) begin
            mode = 0; m_lock = 0; good = 0;
         end else if (mode == 0) begin
            mode = 1; origin = n + 1;
         end else if (r) begin
            if (mode == 2) begin
               m_period = elapsed;
               m_pv = 1;
               if (iabs(elapsed - EXP_PERIOD) <= TOL) begin
                  good++;
                  if (good >= LOCK_CNT) m_lock = 1;
               end else begin
                  setp = 1; good = 0; m_lock = 0;
               end
               if (iabs(2 * m_high - elapsed) > 2 * TOL) setd = 1;
            end
            mode = 2;
            origin = n;
         end else if (elapsed == LOSS_LIMIT) begin
            setl = 1; m_lock = 0; good = 0; mode = 1; origin = n + 1;
         end
         if (r) hi_rise = n;
         if (f) m_high = n - hi_rise;
         m_ep = (m_ep && !clr_err) || setp;
         m_el = (m_el && !clr_err) || setl;
         m_ed = (m_ed && !clr_err) || (setd && DUTY_ON);
         h2 = h1;
         h1 = div_clk_in;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("period", period, m_period);
         chk("period_valid", period_valid, m_pv);
         chk("high_time", high_time, DUTY_ON ? m_high : 0);
         chk("lock", lock, m_lock);
         chk("err_period", err_period, m_ep);
         chk("err_loss", err_loss, m_el);
         chk("err_duty", err_duty, m_ed);
      end
   end

   bit rnd = 1'b0;

   task automatic tick();
      if (rnd) begin
         clr_err = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 299) == 0) en = ~en;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic wave(input int hi, input int lo);
      for (int i = 0; i < hi; i++) begin div_clk_in = 1'b1; tick(); end
      for (int i = 0; i < lo; i++) begin div_clk_in = 1'b0; tick(); end
   endtask

   initial begin
      int pulses, waited;
      bit seen_lock;
      rst = 1'b1; en = 1'b0; div_clk_in = 1'b0; clr_err = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_period", period, 0);
      chk("reset_lock", lock, 0);
      chk("reset_errs", {err_period, err_loss, err_duty}, 0);

      // lock must come with the 4th valid period
      en = 1'b1;
      pulses = 0; seen_lock = 0;
      for (int c = 0; c < 60; c++) begin
         div_clk_in = ((c % 10) < 5);
         tick();
         if (period_valid && !seen_lock) pulses++;
         if (lock) seen_lock = 1;
      end
      chk("lock_pulse_index", pulses, 4);
      chk("lock_after_square", lock, 1);
      chk("period_square", period, 10);
      chk("no_errs_square", {err_period, err_loss}, 0);

      repeat (2) wave(6, 6);
      chk("period_12", period, 12);
      chk("err_period_12", err_period, 1);
      chk("lock_lost_12", lock, 0);
      repeat (6) wave(5, 5);
      chk("relock", lock, 1);
      chk("err_period_sticky", err_period, 1);

      // clear, then a bad period coinciding with clr_err
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("err_cleared", err_period, 0);
      repeat (10) begin div_clk_in = 1'b0; tick(); end
      div_clk_in = 1'b1; tick();
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("set_beats_clear", err_period, 1);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("all_flags_clear", {err_period, err_loss, err_duty}, 0);
      div_clk_in = 1'b0; repeat (5) tick();

      // loss of clock while locked
      repeat (6) wave(5, 5);
      chk("locked_before_loss", lock, 1);
      div_clk_in = 1'b1;
      waited = 0;
      while (!err_loss && waited < 200) begin tick(); waited++; end
      chk("loss_delay", waited, 66);
      chk("lock_after_loss", lock, 0);
      div_clk_in = 1'b0; repeat (5) tick();
      wave(5, 5);
      wave(5, 5);
      chk("period_after_loss", period, 10);

      // synchronous reset while locked
      repeat (5) wave(5, 5);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_outputs", {period, lock, period_valid, err_period, err_loss, err_duty}, 0);
      repeat (7) wave(5, 5);
      en = 1'b0; tick();
      chk("en_off_lock", lock, 0);
      chk("en_off_period_hold", period, 10);
      en = 1'b1;

      // duty check
      repeat (3) wave(3, 7);
      chk("duty_high_time", high_time, DUTY_ON ? 3 : 0);
      chk("duty_err", err_duty, DUTY_ON);

      // randomized run
      rnd = 1'b1;
      repeat (250) begin
         if ($urandom_range(0, 40) == 0) begin
            div_clk_in = 1'b0;
            repeat ($urandom_range(60, 70)) tick();
         end else if ($urandom_range(0, 60) == 0) begin
            rst = 1'b1; tick(); rst = 1'b0;
         end else if ($urandom_range(0, 9) < 7) begin
            wave(5, $urandom_range(4, 6));
         end else begin
            wave($urandom_range(1, 9), $urandom_range(1, 9));
         end
      end
      rnd = 1'b0;
      clr_err = 1'b0;
      en = 1'b1;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
